// File: rtl/disp_pkg.sv
// Shared definitions for the display colour adapter: conversion modes and
// the 4x4 ordered-dither (Bayer) threshold table.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_REPL   = 2'd0,
    MODE_PAD    = 2'd1,
    MODE_DITHER = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Bayer threshold (0..15) at the given row/column.
  function automatic logic [3:0] bayer_val(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'd0:    v = 4'd0;
      4'd1:    v = 4'd8;
      4'd2:    v = 4'd2;
      4'd3:    v = 4'd10;
      4'd4:    v = 4'd12;
      4'd5:    v = 4'd4;
      4'd6:    v = 4'd14;
      4'd7:    v = 4'd6;
      4'd8:    v = 4'd3;
      4'd9:    v = 4'd11;
      4'd10:   v = 4'd1;
      4'd11:   v = 4'd9;
      4'd12:   v = 4'd15;
      4'd13:   v = 4'd7;
      4'd14:   v = 4'd13;
      4'd15:   v = 4'd5;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/disp_dither_pos.sv
// Tracks the screen position (column, row, frame, each mod 4) that selects the
// dither threshold; also flags the vsync rising edge for mode capture.
module disp_dither_pos (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [1:0] cx,
  output logic [1:0] cy,
  output logic [1:0] cf,
  output logic       vs_rise
);

  logic       vs_prev_r;
  logic       de_prev_r;
  logic [1:0] cx_r;
  logic [1:0] cy_r;
  logic [1:0] cf_r;

  assign vs_rise = in_vsync & ~vs_prev_r;
  assign cx      = cx_r;
  assign cy      = cy_r;
  assign cf      = cf_r;

  // Edge history and position counters; a frame start clears the row count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r <= 1'b0;
      de_prev_r <= 1'b0;
      cx_r      <= 2'd0;
      cy_r      <= 2'd0;
      cf_r      <= 2'd0;
    end else begin
      vs_prev_r <= in_vsync;
      de_prev_r <= in_de;
      cx_r      <= in_de ? (cx_r + 2'd1) : 2'd0;
      if (vs_rise) begin
        cy_r <= 2'd0;
        cf_r <= cf_r + 2'd1;
      end else if (de_prev_r && !in_de) begin
        cy_r <= cy_r + 2'd1;
      end
    end
  end

endmodule

// File: rtl/disp_colr_adapt.sv
// Converts pixel colour depth between system and board (replicate, pad or
// ordered dither) with a fixed two-cycle latency on colour and timing.
module disp_colr_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter int CHANS   = 3
) (
  input  logic                     clk_pix,
  input  logic                     rst_pix_n,
  input  logic [1:0]               mode,
  input  logic                     in_hsync,
  input  logic                     in_vsync,
  input  logic                     in_de,
  input  logic [CHANS*BPC_IN-1:0]  in_colr,
  output logic                     out_hsync,
  output logic                     out_vsync,
  output logic                     out_de,
  output logic [CHANS*BPC_OUT-1:0] out_colr
);

  localparam int D       = (BPC_IN > BPC_OUT) ? (BPC_IN - BPC_OUT) : 0;
  localparam int SHR     = (D <= 4) ? (4 - D) : 0;
  localparam int SHL     = (D > 4) ? (D - 4) : 0;
  localparam bit DITH_OK = (BPC_OUT < BPC_IN);

  logic [1:0]               cx_s;
  logic [1:0]               cy_s;
  logic [1:0]               cf_s;
  logic                     vs_rise_s;
  mode_e                    act_mode_r;
  mode_e                    s1_mode_r;
  logic                     s1_hs_r;
  logic                     s1_vs_r;
  logic                     s1_de_r;
  logic [CHANS*BPC_IN-1:0]  s1_colr_r;
  logic [3:0]               s1_t_r;
  logic [BPC_IN:0]          ts_s;
  logic [CHANS*BPC_OUT-1:0] conv_s;

  disp_dither_pos u_pos (
    .clk      (clk_pix),
    .rst_n    (rst_pix_n),
    .in_vsync (in_vsync),
    .in_de    (in_de),
    .cx       (cx_s),
    .cy       (cy_s),
    .cf       (cf_s),
    .vs_rise  (vs_rise_s)
  );

  // Stage 1: capture the pixel with the mode and threshold in force before this edge.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      act_mode_r <= MODE_REPL;
      s1_mode_r  <= MODE_REPL;
      s1_hs_r    <= 1'b0;
      s1_vs_r    <= 1'b0;
      s1_de_r    <= 1'b0;
      s1_colr_r  <= '0;
      s1_t_r     <= 4'd0;
    end else begin
      if (vs_rise_s) begin
        act_mode_r <= mode_e'(mode);
      end
      s1_mode_r <= act_mode_r;
      s1_hs_r   <= in_hsync;
      s1_vs_r   <= in_vsync;
      s1_de_r   <= in_de;
      s1_colr_r <= in_colr;
      s1_t_r    <= bayer_val(cy_s + cf_s, cx_s);
    end
  end

  // Threshold scaled to the number of dropped bits.
  assign ts_s = (BPC_IN + 1)'(({12'd0, s1_t_r} >> SHR) << SHL);

  for (genvar ch = 0; ch < CHANS; ch++) begin : g_chan
    logic [BPC_IN-1:0]  cin_s;
    logic [BPC_IN:0]    sum_s;
    logic [BPC_OUT-1:0] rep_s;
    logic [BPC_OUT-1:0] pad_s;
    logic [BPC_OUT-1:0] dith_s;
    logic [BPC_OUT-1:0] res_s;

    assign cin_s = s1_colr_r[ch*BPC_IN +: BPC_IN];
    assign sum_s = {1'b0, cin_s} + ts_s;

    // Output bit b (from the MSB) takes input bit b mod BPC_IN; the carry saturates dither.
    for (genvar b = 0; b < BPC_OUT; b++) begin : g_bit
      localparam int SRC = BPC_IN - 1 - (b % BPC_IN);
      assign rep_s[BPC_OUT-1-b]  = cin_s[SRC];
      assign pad_s[BPC_OUT-1-b]  = (b < BPC_IN) ? cin_s[SRC] : 1'b0;
      assign dith_s[BPC_OUT-1-b] = sum_s[SRC] | sum_s[BPC_IN];
    end

    // Mode select; reserved mode and non-reducing dither fall back to replicate.
    always_comb begin
      case (s1_mode_r)
        MODE_PAD:    res_s = pad_s;
        MODE_DITHER: res_s = DITH_OK ? dith_s : rep_s;
        default:     res_s = rep_s;
      endcase
    end

    assign conv_s[ch*BPC_OUT +: BPC_OUT] = res_s;
  end

  // Stage 2: registered outputs, colour blanked outside active video.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      out_colr  <= '0;
    end else begin
      out_hsync <= s1_hs_r;
      out_vsync <= s1_vs_r;
      out_de    <= s1_de_r;
      out_colr  <= s1_de_r ? conv_s : '0;
    end
  end

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Randomised bench for disp_colr_adapt in an expanding (5->8) and a reducing
// (8->5) configuration against an arithmetic reference model.
module tb_disp_colr_adapt;

  logic        clk_pix   = 1'b0;
  logic        rst_pix_n = 1'b0;
  logic [1:0]  mode      = 2'd0;
  logic        hs        = 1'b0;
  logic        vs        = 1'b0;
  logic        de        = 1'b0;
  logic [14:0] c_in_up   = '0;
  logic [23:0] c_in_dn   = '0;

  logic        o_hs_up, o_vs_up, o_de_up;
  logic [23:0] o_c_up;
  logic        o_hs_dn, o_vs_dn, o_de_dn;
  logic [14:0] o_c_dn;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  tim;
    logic [23:0] c_up;
    logic [14:0] c_dn;
  } exp_t;
  exp_t q[$];

  int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  int m_cx, m_cy, m_cf, m_mode;
  bit m_pvs, m_pde;

  always #5 clk_pix = ~clk_pix;

  disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANS(3)) u_dut_up (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode),
    .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c_in_up),
    .out_hsync(o_hs_up), .out_vsync(o_vs_up), .out_de(o_de_up), .out_colr(o_c_up)
  );

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANS(3)) u_dut_dn (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode),
    .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c_in_dn),
    .out_hsync(o_hs_dn), .out_vsync(o_vs_dn), .out_de(o_de_dn), .out_colr(o_c_dn)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One channel: replicate, pad, truncate or dither using plain integer arithmetic.
  function automatic int conv_ch(int v, int bin, int bout, int m, int t);
    int md, d, ts, s, acc, w;
    md = (m == 3) ? 0 : m;
    if (md == 2 && bout >= bin) md = 0;
    if (md == 2) begin
      d  = bin - bout;
      ts = (d <= 4) ? (t >> (4 - d)) : (t << (d - 4));
      s  = v + ts;
      if (s >= (1 << bin)) return (1 << bout) - 1;
      return s >> d;
    end
    if (bout <= bin) return v >> (bin - bout);
    if (md == 1) return v << (bout - bin);
    acc = 0;
    w   = 0;
    while (w < bout) begin
      acc = (acc << bin) | v;
      w  += bin;
    end
    return acc >> (w - bout);
  endfunction

  function automatic int conv_pix(int c, int bin, int bout, int m, int t);
    int r = 0;
    for (int ch = 0; ch < 3; ch++)
      r |= conv_ch((c >> (ch * bin)) & ((1 << bin) - 1), bin, bout, m, t) << (ch * bout);
    return r;
  endfunction

  task automatic model_reset();
    m_cx = 0; m_cy = 0; m_cf = 0; m_mode = 0; m_pvs = 1'b0; m_pde = 1'b0;
  endtask

  // One pixel clock: check the output due now, drive new inputs, predict their result.
  task automatic step(input logic h, input logic v, input logic d, input logic [1:0] md,
                      input logic [14:0] a, input logic [23:0] b);
    exp_t e;
    int   t;
    @(negedge clk_pix);
    if (q.size() >= 2) begin
      e = q.pop_front();
      check_val("tim_up",  {29'd0, o_hs_up, o_vs_up, o_de_up}, {29'd0, e.tim});
      check_val("colr_up", {8'd0, o_c_up}, {8'd0, e.c_up});
      check_val("tim_dn",  {29'd0, o_hs_dn, o_vs_dn, o_de_dn}, {29'd0, e.tim});
      check_val("colr_dn", {17'd0, o_c_dn}, {17'd0, e.c_dn});
    end
    hs = h; vs = v; de = d; mode = md; c_in_up = a; c_in_dn = b;
    t      = bayer[((m_cy + m_cf) % 4) * 4 + m_cx];
    e.tim  = {h, v, d};
    e.c_up = d ? 24'(conv_pix(int'(a), 5, 8, m_mode, t)) : 24'd0;
    e.c_dn = d ? 15'(conv_pix(int'(b), 8, 5, m_mode, t)) : 15'd0;
    q.push_back(e);
    if (v && !m_pvs) begin
      m_cy   = 0;
      m_cf   = (m_cf + 1) % 4;
      m_mode = int'(md);
    end else if (m_pde && !d) begin
      m_cy = (m_cy + 1) % 4;
    end
    m_cx  = d ? (m_cx + 1) % 4 : 0;
    m_pvs = v;
    m_pde = d;
  endtask

  // msel 0..3 holds mode fixed, 4 picks a random mode every cycle.
  task automatic px(input logic h, input logic v, input logic d, input int msel, input bit fixed_col);
    logic [1:0]  md;
    logic [14:0] a;
    logic [23:0] b;
    md = (msel < 4) ? 2'(msel) : 2'($urandom_range(0, 3));
    a  = fixed_col ? {3{5'h02}} : 15'($urandom);
    b  = fixed_col ? {3{8'h04}} : 24'($urandom);
    step(h, v, d, md, a, b);
  endtask

  task automatic run_frame(input int lines, input int msel, input bit fixed_col);
    int w;
    px(1'b0, 1'b1, 1'b0, msel, fixed_col);
    px(1'b0, 1'b1, 1'b0, msel, fixed_col);
    for (int l = 0; l < lines; l++) begin
      w = $urandom_range(3, 7);
      for (int p = 0; p < w; p++) px(1'b0, 1'b0, 1'b1, msel, fixed_col);
      px(1'b1, 1'b0, 1'b0, msel, fixed_col);
      px(1'b1, 1'b0, 1'b0, msel, fixed_col);
      px(1'b0, 1'b0, 1'b0, msel, fixed_col);
    end
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    hs = 1'b0; vs = 1'b0; de = 1'b0;
    rst_pix_n = 1'b0;
    #1;
    check_val("rst_async_up", {5'd0, o_hs_up, o_vs_up, o_de_up, o_c_up}, 32'd0);
    check_val("rst_async_dn", {14'd0, o_hs_dn, o_vs_dn, o_de_dn, o_c_dn}, 32'd0);
    repeat (3) begin
      @(negedge clk_pix);
      check_val("rst_hold_up", {5'd0, o_hs_up, o_vs_up, o_de_up, o_c_up}, 32'd0);
      check_val("rst_hold_dn", {14'd0, o_hs_dn, o_vs_dn, o_de_dn, o_c_dn}, 32'd0);
    end
    #1 rst_pix_n = 1'b1;
    q.delete();
    q.push_back('0);
    q.push_back('0);
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk_pix);
    do_reset();

    // Mode pin changes mid-frame must wait for the next vsync rise.
    step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 2'd1, {3{5'b10101}}, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    check_val("repl_ad", {8'd0, o_c_up}, 32'h00ADADAD);
    step(1'b0, 1'b1, 1'b0, 2'd1, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    step(1'b0, 1'b0, 1'b1, 2'd1, {3{5'b10101}}, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    check_val("pad_a8", {8'd0, o_c_up}, 32'h00A8A8A8);

    // Walk the frame counter round to 0 while entering dither mode.
    while (m_cf != 3) begin
      step(1'b0, 1'b1, 1'b0, 2'd2, '0, '0);
      step(1'b0, 1'b0, 1'b0, 2'd2, '0, '0);
    end
    step(1'b0, 1'b1, 1'b0, 2'd2, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd2, '0, '0);
    step(1'b0, 1'b0, 1'b1, 2'd2, '0, {3{8'h04}});
    step(1'b0, 1'b0, 1'b1, 2'd2, '0, {3{8'h04}});
    step(1'b0, 1'b0, 1'b0, 2'd2, '0, '0);
    check_val("dith_cx0", {17'd0, o_c_dn}, 32'h00000000);
    step(1'b0, 1'b0, 1'b0, 2'd2, '0, '0);
    check_val("dith_cx1", {17'd0, o_c_dn}, 32'h00000421);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, (k < 4), 2'd2, '0, 24'hFFFFFF);
      if (k >= 2) check_val("dith_sat", {17'd0, o_c_dn}, 32'h00007FFF);
    end

    // Constant field in dither mode over more than four frames.
    repeat (5) run_frame(5, 2, 1'b1);
    repeat (4) run_frame(6, 4, 1'b0);

    // Reset in the middle of a line: mode falls back to replicate.
    px(1'b0, 1'b0, 1'b1, 1, 1'b0);
    px(1'b0, 1'b0, 1'b1, 1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2'd1, {3{5'b10101}}, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd1, '0, '0);
    check_val("rst_mode0", {8'd0, o_c_up}, 32'h00ADADAD);
    repeat (4) run_frame(5, 4, 1'b0);
    run_frame(3, 2, 1'b0);
    px(1'b0, 1'b0, 1'b0, 2, 1'b0);
    px(1'b0, 1'b0, 1'b0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
